// File: rtl/i2c_scan_code_rx_fifo_if.sv
// i2c_scan_code_rx_fifo_if: valid/ready byte stream from the I2C receive FIFO to downstream logic.
interface i2c_scan_code_rx_fifo_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    modport master (output data_out, data_valid, input data_ready);
    modport slave  (input data_out, data_valid, output data_ready);
endinterface

// File: rtl/i2c_scan_code_rx_fifo.sv
// i2c_scan_code_rx_fifo: I2C slave receiver that queues written bytes in a FWFT FIFO with back-pressure.
module i2c_scan_code_rx_fifo #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h42,
    parameter bit         ADDR_MATCH_EN = 1'b1,
    parameter int         FIFO_DEPTH    = 8,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic                             fpga_clock,
    input  logic                             rst_n,
    input  logic                             scl,
    input  logic                             sda_in,
    output logic                             sda_oe,
    i2c_scan_code_rx_fifo_if.master          rx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    input  logic                             clear_overflow,
    output logic                             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start_c, stop_c;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic ack_go, ack_on;
    logic byte_done, addr_ok, full, pop, try_push, push;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_c   = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_c    = scl_s & scl_q & ~sda_q & sda_s;
    assign byte_done = scl_rise && bit_cnt == 3'd7;
    // At the 8th rising edge shreg holds the 7 address bits and sda_s is R/W
    assign addr_ok   = (!ADDR_MATCH_EN || shreg == SLAVE_ADDR) && !sda_s;
    assign full      = fifo_count == CW'(FIFO_DEPTH);
    assign pop       = rx.data_valid & rx.data_ready;
    assign try_push  = state == DATA && byte_done;
    assign push      = try_push & (~full | pop);
    assign rx.data_valid = fifo_count != '0;
    assign rx.data_out   = rx.data_valid ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end
    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
            ack_go  <= 1'b0;
            ack_on  <= 1'b0;
        end else if (start_c) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            ack_on  <= 1'b0;
        end else if (stop_c) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            ack_on <= 1'b0;
        end else begin
            if (scl_rise) begin
                shreg   <= {shreg[5:0], sda_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                ADDR: if (byte_done) begin
                    state  <= addr_ok ? ADDR_ACK : IGNORE;
                    busy   <= addr_ok;
                    ack_go <= 1'b1;
                end
                DATA: if (byte_done) begin
                    state  <= DATA_ACK;
                    ack_go <= push;
                end
                // First falling edge drives the ACK, the next one (end of 9th clock) releases it
                ADDR_ACK, DATA_ACK: if (scl_fall) begin
                    sda_oe <= ~ack_on & ack_go;
                    ack_on <= ~ack_on;
                    if (ack_on) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            overflow   <= (try_push & ~push) | (overflow & ~clear_overflow);
        end
    end
    always_ff @(posedge fpga_clock) begin
        if (push) mem[wr_ptr] <= {shreg, sda_s};
    end
endmodule

// File: tb/tb_i2c_scan_code_rx_fifo.sv
// tb_i2c_scan_code_rx_fifo: directed I2C master stimulus against a matching and a legacy-mode receiver.
module tb_i2c_scan_code_rx_fifo;
    localparam int PH = 12;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;
    logic rdy0 = 1'b0, rdy1 = 1'b0, clr = 1'b0;
    logic oe0, oe1, ov0, ov1, busy0, busy1;
    logic [3:0] cnt0, cnt1;
    logic scl0, sda0, scl1, sda1;
    logic oe_seen = 1'b0, busy_seen = 1'b0;
    logic ack;
    int n_cmp = 0, n_err = 0;
    logic [7:0] burst [9] = '{8'h23, 8'h43, 8'h21, 8'h42, 8'h32, 8'h3C, 8'h2C, 8'h2C, 8'h1C};
    assign scl0 = sel ? 1'b1 : scl_m;
    assign sda0 = sel ? 1'b1 : (sda_m & ~oe0);
    assign scl1 = sel ? scl_m : 1'b1;
    assign sda1 = sel ? (sda_m & ~oe1) : 1'b1;
    i2c_scan_code_rx_fifo_if s0 ();
    i2c_scan_code_rx_fifo_if s1 ();
    assign s0.data_ready = rdy0;
    assign s1.data_ready = rdy1;
    i2c_scan_code_rx_fifo u_dut (
        .fpga_clock(clk), .rst_n(rst_n), .scl(scl0), .sda_in(sda0), .sda_oe(oe0), .rx(s0),
        .fifo_count(cnt0), .overflow(ov0), .clear_overflow(clr), .busy(busy0));
    i2c_scan_code_rx_fifo #(.ADDR_MATCH_EN(1'b0)) u_leg (
        .fpga_clock(clk), .rst_n(rst_n), .scl(scl1), .sda_in(sda1), .sda_oe(oe1), .rx(s1),
        .fifo_count(cnt1), .overflow(ov1), .clear_overflow(clr), .busy(busy1));
    always @(posedge clk) begin
        if (oe0) oe_seen = 1'b1;
        if (busy0) busy_seen = 1'b1;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic phase();
        repeat (PH) @(posedge clk);
        #1;
    endtask
    task automatic i2c_start();
        sda_m = 1'b1; phase();
        scl_m = 1'b1; phase();
        sda_m = 1'b0; phase();
        scl_m = 1'b0; phase();
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; phase();
        scl_m = 1'b1; phase();
        sda_m = 1'b1; phase();
    endtask
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; phase();
            scl_m = 1'b1;   phase();
            scl_m = 1'b0;   phase();
        end
    endtask
    task automatic ack_bit(output logic a);
        sda_m = 1'b1; phase();
        scl_m = 1'b1; phase();
        a = sel ? oe1 : oe0;
        scl_m = 1'b0; phase();
    endtask
    task automatic send_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8);
        ack_bit(a);
    endtask
    task automatic pop0();
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b0;
    endtask
    initial begin
        #1;
        check("rst_oe", oe0, 0);
        check("rst_valid", s0.data_valid, 0);
        check("rst_data", s0.data_out, 0);
        check("rst_count", cnt0, 0);
        check("rst_ovf", ov0, 0);
        check("rst_busy", busy0, 0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        phase();
        // Basic write: address 0x42, data 0x23, with latency check on the 8th data edge
        i2c_start();
        send_byte(8'h84, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_busy", busy0, 1);
        send_bits(8'h23, 7);
        check("t1_pre_valid", s0.data_valid, 0);
        sda_m = 1'b1; phase();
        scl_m = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("t1_latency", s0.data_valid, 1);
        repeat (PH - 4) @(posedge clk); #1;
        scl_m = 1'b0; phase();
        ack_bit(ack);
        check("t1_data_ack", ack, 1);
        i2c_stop();
        check("t1_busy_idle", busy0, 0);
        check("t1_count", cnt0, 1);
        check("t1_data", s0.data_out, 8'h23);
        pop0();
        check("t1_count_pop", cnt0, 0);
        check("t1_valid_pop", s0.data_valid, 0);
        // Wrong address: no ACK, nothing queued, never busy
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        send_byte(8'h86, ack);
        check("t2_addr_nack", ack, 0);
        send_byte(8'h1C, ack);
        check("t2_data_nack", ack, 0);
        i2c_stop();
        check("t2_oe_seen", oe_seen, 0);
        check("t2_busy_seen", busy_seen, 0);
        check("t2_count", cnt0, 0);
        // Overflow: nine bytes into an 8-deep FIFO with no consumer
        i2c_start();
        send_byte(8'h84, ack);
        check("t3_addr_ack", ack, 1);
        for (int i = 0; i < 9; i++) begin
            send_byte(burst[i], ack);
            check($sformatf("t3_ack%0d", i), ack, i < 8 ? 1 : 0);
        end
        i2c_stop();
        check("t3_ovf", ov0, 1);
        check("t3_count", cnt0, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain%0d", i), s0.data_out, burst[i]);
            pop0();
        end
        check("t3_empty", cnt0, 0);
        check("t3_ovf_sticky", ov0, 1);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        check("t3_ovf_clr", ov0, 0);
        // Repeated START mid-byte discards the partial byte
        i2c_start();
        send_byte(8'h84, ack);
        send_bits(8'hFF, 5);
        i2c_start();
        send_byte(8'h84, ack);
        check("t4_addr_ack", ack, 1);
        send_byte(8'h42, ack);
        check("t4_data_ack", ack, 1);
        i2c_stop();
        check("t4_count", cnt0, 1);
        check("t4_data", s0.data_out, 8'h42);
        pop0();
        // Read request to own address is ignored
        busy_seen = 1'b0;
        i2c_start();
        send_byte(8'h85, ack);
        check("t5_read_nack", ack, 0);
        send_byte(8'h55, ack);
        check("t5_ignore_nack", ack, 0);
        i2c_stop();
        check("t5_count", cnt0, 0);
        check("t5_busy_seen", busy_seen, 0);
        // Legacy instance accepts any write address
        sel = 1'b1;
        i2c_start();
        send_byte(8'h20, ack);
        check("t6_addr_ack", ack, 1);
        send_byte(8'h5A, ack);
        check("t6_data_ack", ack, 1);
        i2c_stop();
        check("t6_count", cnt1, 1);
        check("t6_data", s1.data_out, 8'h5A);
        sel = 1'b0;
        // Reset asserted while the address ACK is being driven
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'h11, ack);
        i2c_stop();
        check("t7_pre_count", cnt0, 1);
        i2c_start();
        send_bits(8'h84, 8);
        check("t7_oe_on", oe0, 1);
        check("t7_busy_on", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("t7_oe_async", oe0, 0);
        check("t7_busy_rst", busy0, 0);
        check("t7_count_rst", cnt0, 0);
        check("t7_valid_rst", s0.data_valid, 0);
        check("t7_data_rst", s0.data_out, 0);
        check("t7_leg_count_rst", cnt1, 0);
        sda_m = 1'b1; scl_m = 1'b1;
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b1;
        phase();
        i2c_start();
        send_byte(8'h84, ack);
        check("t7_addr_ack", ack, 1);
        send_byte(8'h77, ack);
        check("t7_data_ack", ack, 1);
        i2c_stop();
        check("t7_count", cnt0, 1);
        check("t7_data", s0.data_out, 8'h77);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_scan_code_rx_fifo.md
Name: i2c_scan_code_rx_fifo

Overview:
Parametrised successor of the I2C keyboard scan-code interface. It is an I2C slave-receiver with a pin synchroniser, START/STOP detection, address match, and ACK/NACK generation via open-drain SDA. Received bytes are buffered in a FIFO and presented on a valid/ready stream to downstream FPGA logic. It replaces the single-register 8-bit output, which had no back-pressure.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit I2C address acknowledged by this block
ADDR_MATCH_EN, 1, 1 = ACK only SLAVE_ADDR; 0 = legacy mode (accept any address, write only)
FIFO_DEPTH, 8, byte entries in receive FIFO (power of 2, >=2)
SYNC_STAGES, 2, flops on scl/sda inputs (>=2)

Ports:
fpga_clock  in  1  system clock, >=8x SCL rate
rst_n  in  1  asynchronous active-low reset
scl  in  1  I2C clock from bus
sda_in  in  1  I2C data sampled from bus
sda_oe  out  1  1 = pull SDA low (ACK); 0 = release
data_out  out  8  FIFO head byte
data_valid  out  1  FIFO non-empty
data_ready  in  1  consumer accepts head this cycle
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
overflow  out  1  sticky: byte dropped because FIFO full
clear_overflow  in  1  clears overflow
busy  out  1  addressed transaction in progress (ADDR_ACK..DATA_ACK)

Behaviour:
- Reset (async, rst_n=0): sda_oe=0 immediately; data_valid=0, data_out=0, fifo_count=0, overflow=0, busy=0; FSM=IDLE; synchronisers load 1.
- scl/sda pass through SYNC_STAGES flops; edges are detected on the synced values only.
- START = synced sda falls while synced scl=1. STOP = synced sda rises while synced scl=1. Both are valid in every state.
- START (including repeated START) -> ADDR; clear the bit counter and discard any partial byte.
- STOP -> IDLE; sda_oe=0.
- Bits are sampled on synced scl rising edges, MSB first; bit counter runs 0..7.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- ADDR: after the 8th bit, a match (addr==SLAVE_ADDR, or ADDR_MATCH_EN=0) with R/W=0 -> ADDR_ACK. Mismatch or R/W=1 -> IGNORE (no ACK).
- ADDR_ACK / DATA_ACK drive timing: sda_oe asserts on the first scl falling edge after the 8th bit. It is held through the 9th-clock high phase and released on the following scl falling edge. The FSM then goes to DATA.
- DATA: on the 8th rising edge the byte is completed and a push is attempted.
  - Push accepted if the FIFO is not full, or a pop occurs in the same cycle -> DATA_ACK with ACK.
  - Otherwise the byte is dropped, overflow=1, and the FSM enters DATA_ACK with NACK (sda_oe stays 0).
- IGNORE: sda_oe=0 until START or STOP.
- FIFO is first-word-fall-through.
  - data_out is valid whenever data_valid=1; pop when data_valid&data_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: a pushed byte appears on data_out with data_valid=1 no later than SYNC_STAGES+2 fpga_clock cycles after the 8th SCL rising edge at the pin.
- overflow: cleared by clear_overflow; if a set and a clear occur in the same cycle, set wins.
- busy=1 in ADDR_ACK, DATA, DATA_ACK; 0 otherwise.
- Reset mid-transfer: abort with no byte pushed and SDA released; the next START starts cleanly.

Test Plan:
- Write to 0x42 (byte 0x84) then data 0x23, STOP, data_ready=1 -> ACK on 9th clock of both bytes; data_out=0x23 with data_valid=1 for 1 cycle; fifo_count 1->0.
- Write to address 0x43, data 0x1C -> sda_oe never asserts; fifo_count stays 0; busy stays 0.
- data_ready=0, FIFO_DEPTH=8, send 9 bytes (0x23,0x43,0x21,0x42,0x32,0x3C,0x2C,0x2C,0x1C):
  - first 8 ACKed, 9th NACKed; overflow=1; fifo_count=8.
  - Draining yields bytes 1-8 in order.
  - clear_overflow -> overflow=0.
- Repeated START after 5 data bits, then address 0x84 plus data 0x42 -> partial byte discarded; only 0x42 queued.
- Address byte 0x85 (read) -> NACK, IGNORE until STOP; nothing queued. With ADDR_MATCH_EN=0, address 0x10 write -> ACKed and data queued.
- rst_n low while sda_oe=1 during an ACK -> sda_oe=0 in the same cycle (async); all outputs reset; the next full transaction works normally.
